// File: rtl/sync_fifo_wrapper_pkg.sv
// Shared defaults and elaboration helpers for the byte-stream FIFO.
package sync_fifo_wrapper_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 128;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction
endpackage

// File: rtl/sync_fifo_wrapper_fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset; count gates what is visible.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_wrapper.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
module sync_fifo_wrapper
  import sync_fifo_wrapper_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_data,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_data,
  output logic             output_valid,
  input  logic             output_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  generate
    if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("sync_fifo_wrapper: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] rdata;
  logic             push, pop;

  // Flags come only from registered count, never from same-cycle inputs.
  assign input_ready  = !reset && (count != FULL);
  assign output_valid = !reset && (count != '0);
  assign output_data  = output_valid ? rdata : '0;

  assign push = input_valid && input_ready;
  assign pop  = output_valid && output_ready;

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (input_data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_sync_fifo_wrapper.sv
// Scoreboard bench: accepted writes feed a queue model, a negedge monitor checks flags and data.
module tb_sync_fifo_wrapper;
  localparam int W = 8;
  localparam int D = 128;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] input_data;
  logic         input_valid;
  logic         input_ready;
  logic [W-1:0] output_data;
  logic         output_valid;
  logic         output_ready;

  sync_fifo_wrapper #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int pops   = 0;
  int npush  = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Input side of the scoreboard: every accepted word becomes an expected output.
  always @(posedge clk) begin
    if (reset) q.delete();
    else if (input_valid && input_ready) begin
      q.push_back(input_data);
      npush++;
    end
  end

  // Output monitor: flags and head word derived from the queue model.
  always @(negedge clk) begin
    if (mon_en) begin
      logic         exp_rdy, exp_vld;
      logic [W-1:0] exp_dat;
      exp_rdy = !reset && (q.size() != D);
      exp_vld = !reset && (q.size() != 0);
      exp_dat = exp_vld ? q[0] : '0;
      chk("input_ready", input_ready, exp_rdy);
      chk("output_valid", output_valid, exp_vld);
      chk("output_data", output_data, exp_dat);
      if (exp_vld && output_ready) begin
        void'(q.pop_front());
        pops++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int exp_n, input string name);
    int n;
    n = 0;
    pops = 0;
    input_valid = 1'b0;
    output_ready = 1'b1;
    while (output_valid && n < 400) begin
      step();
      n++;
    end
    output_ready = 1'b0;
    chk(name, pops, exp_n);
  endtask

  initial begin
    reset = 1'b1;
    input_valid = 1'b1;
    input_data = 8'h11;
    output_ready = 1'b0;
    step();
    mon_en = 1'b1;
    repeat (9) step();
    reset = 1'b0;
    input_valid = 1'b0;
    step();

    // Single word, visible the cycle after acceptance.
    input_valid = 1'b1;
    input_data = 8'hA5;
    step();
    input_valid = 1'b0;
    chk("single_data", output_data, 8'hA5);
    step();
    output_ready = 1'b1;
    step();
    output_ready = 1'b0;
    chk("single_gone", output_valid, 1'b0);
    step();

    // Fill to full, then offer extra words that must be refused.
    for (int i = 0; i < D; i++) begin
      input_valid = 1'b1;
      input_data = W'(i);
      step();
    end
    input_data = 8'hFF;
    chk("full_ready", input_ready, 1'b0);
    repeat (2) step();
    // Pop at full: the push in the same cycle is refused, accepted next cycle.
    output_ready = 1'b1;
    step();
    output_ready = 1'b0;
    chk("ready_after_pop", input_ready, 1'b1);
    step();
    input_valid = 1'b0;
    drain(D, "full_drain_count");
    step();

    // Five queued, then 20 cycles of concurrent push and pop.
    for (int i = 0; i < 5; i++) begin
      input_valid = 1'b1;
      input_data = W'(8'hB0 + i);
      step();
    end
    input_valid = 1'b0;
    pops = 0;
    output_ready = 1'b1;
    input_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      input_data = W'(8'hC0 + i);
      step();
    end
    input_valid = 1'b0;
    output_ready = 1'b0;
    chk("concurrent_pops", pops, 20);
    drain(5, "concurrent_left");

    // Random traffic across many pointer wraps; producer holds data until accepted.
    npush = 0;
    input_valid = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      logic acc;
      @(negedge clk);
      acc = input_valid && input_ready;
      @(posedge clk);
      #1;
      if (!input_valid || acc) begin
        input_valid = 1'($urandom_range(0, 1));
        input_data = W'($urandom);
      end
      output_ready = 1'($urandom_range(0, 1));
    end
    input_valid = 1'b0;
    chk("random_volume", (npush >= 300), 1'b1);
    drain(q.size(), "random_drain");

    // Reset mid-operation discards the queue.
    for (int i = 0; i < 40; i++) begin
      input_valid = 1'b1;
      input_data = W'(8'h50 + i);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    input_valid = 1'b0;
    chk("post_reset_valid", output_valid, 1'b0);
    input_valid = 1'b1;
    input_data = 8'h3C;
    step();
    input_data = 8'h3D;
    step();
    input_valid = 1'b0;
    chk("post_reset_first", output_data, 8'h3C);
    drain(2, "post_reset_drain");
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
